// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched word into an execute bundle and holds it
// in a two-entry elastic buffer (output register plus skid register).
package decode_stage_pkg;
  localparam int unsigned XLEN_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_LT  = 4'd3,
    ALU_LTU = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_OR  = 4'd8,
    ALU_AND = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e            alu_op;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic [XLEN_W-1:0]  imm;
    logic               src1_pc;
    logic               src2_imm;
    logic               wb_en;
    logic               mem_rd;
    logic               mem_wr;
    logic               branch;
    logic               jump;
    logic [2:0]         funct3;
    logic               illegal;
    logic [XLEN_W-1:0]  pc;
  } bundle_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_src1_pc,
  output logic            out_src2_imm,
  output logic            out_wb_en,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_branch,
  output logic            out_jump,
  output logic [2:0]      out_funct3,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} buf_state_e;

  buf_state_e state_q, state_d;
  bundle_t    out_q, out_d, skid_q, skid_d, dec;
  logic       in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic       accept, drain, uses_rd, illegal;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  // Shared funct3 -> ALU op map for OP and OP-IMM; bit 30 selects SRA.
  function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_LT;
      3'b011:  f3_alu = ALU_LTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin : decode
    opcode       = in_instr[6:0];
    funct3       = in_instr[14:12];
    funct7       = in_instr[31:25];
    uses_rd      = 1'b0;
    illegal      = 1'b0;
    dec          = '0;
    dec.alu_op   = ALU_ADD;
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.rd       = in_instr[11:7];
    dec.funct3   = funct3;
    dec.pc       = 32'(in_pc);
    case (opcode)
      OPC_LUI: begin
        dec.rs1      = '0;
        dec.imm      = {in_instr[31:12], 12'b0};
        dec.src2_imm = 1'b1;
        uses_rd      = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm      = {in_instr[31:12], 12'b0};
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
        uses_rd      = 1'b1;
      end
      OPC_JAL: begin
        dec.imm      = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
        dec.jump     = 1'b1;
        uses_rd      = 1'b1;
      end
      OPC_JALR: begin
        dec.imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_imm = 1'b1;
        dec.jump     = 1'b1;
        uses_rd      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm    = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        dec.branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec.alu_op = ALU_SUB;
          3'b100, 3'b101: dec.alu_op = ALU_LT;
          3'b110, 3'b111: dec.alu_op = ALU_LTU;
          default:        illegal    = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_imm = 1'b1;
        dec.mem_rd   = 1'b1;
        uses_rd      = 1'b1;
      end
      OPC_STORE: begin
        dec.imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.src2_imm = 1'b1;
        dec.mem_wr   = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm      = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.src2_imm = 1'b1;
        dec.alu_op   = f3_alu(funct3, in_instr[30]);
        uses_rd      = 1'b1;
        // Shift immediates carry only the 5-bit shamt; funct7 must be clean.
        if (funct3 == 3'b001) begin
          dec.imm = 32'(in_instr[24:20]);
          illegal = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          dec.imm = 32'(in_instr[24:20]);
          illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      OPC_OP: begin
        dec.alu_op = f3_alu(funct3, in_instr[30]);
        uses_rd    = 1'b1;
        if (funct3 == 3'b000 && in_instr[30]) dec.alu_op = ALU_SUB;
        if ((funct7 != 7'h00) && (funct7 != 7'h20)) illegal = 1'b1;
        if ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101)) illegal = 1'b1;
      end
      OPC_FENCE: ;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec.alu_op = ALU_ADD;
      dec.mem_rd = 1'b0;
      dec.mem_wr = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
    end
    dec.illegal = illegal;
    dec.wb_en   = uses_rd && !illegal && (dec.rd != '0);
  end

  // Elastic buffer next-state; flush overrides any same-cycle movement.
  always_comb begin : buffer_next
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    accept  = in_valid && in_ready_q;
    drain   = out_valid_q && out_ready;
    case (state_q)
      EMPTY: if (accept) begin
        out_d   = dec;
        state_d = ONE;
      end
      ONE: begin
        if (accept && drain) begin
          out_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = TWO;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: if (drain) begin
        out_d   = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_alu_op   = out_q.alu_op;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_imm      = XLEN'(out_q.imm);
  assign out_src1_pc  = out_q.src1_pc;
  assign out_src2_imm = out_q.src2_imm;
  assign out_wb_en    = out_q.wb_en;
  assign out_mem_rd   = out_q.mem_rd;
  assign out_mem_wr   = out_q.mem_wr;
  assign out_branch   = out_q.branch;
  assign out_jump     = out_q.jump;
  assign out_funct3   = out_q.funct3;
  assign out_illegal  = out_q.illegal;
  assign out_pc       = XLEN'(out_q.pc);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles queued at accept, compared at drain.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_LT = 4'd3, A_LTU = 4'd4,
                         A_SRA = 4'd7, A_AND = 4'd9;

  typedef struct packed {
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        s1pc, s2imm, wb, mrd, mwr, br, jmp;
    logic [2:0]  f3;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_src1_pc, out_src2_imm, out_wb_en, out_mem_rd, out_mem_wr;
  logic        out_branch, out_jump, out_illegal;
  logic [2:0]  out_funct3;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] cur_pc = 32'h0000_1000;
  exp_t        sb_q[$];
  string       tag_q[$];

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_src1_pc(out_src1_pc), .out_src2_imm(out_src2_imm), .out_wb_en(out_wb_en),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_branch(out_branch),
    .out_jump(out_jump), .out_funct3(out_funct3), .out_illegal(out_illegal),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // flags = {src1_pc, src2_imm, wb_en, mem_rd, mem_wr, branch, jump}
  function automatic exp_t mk(input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm, input logic [6:0] flags,
                              input logic [2:0] f3, input logic ill);
    exp_t e;
    e = '{alu: alu, rs1: rs1, rs2: rs2, rd: rd, imm: imm,
          s1pc: flags[6], s2imm: flags[5], wb: flags[4], mrd: flags[3], mwr: flags[2],
          br: flags[1], jmp: flags[0], f3: f3, ill: ill, pc: 32'h0};
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = '{alu: out_alu_op, rs1: out_rs1, rs2: out_rs2, rd: out_rd, imm: out_imm,
          s1pc: out_src1_pc, s2imm: out_src2_imm, wb: out_wb_en, mrd: out_mem_rd,
          mwr: out_mem_wr, br: out_branch, jmp: out_jump, f3: out_funct3,
          ill: out_illegal, pc: out_pc};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  // One cycle: sample at negedge, retire a drained bundle, then step past the posedge.
  task automatic tick(output bit acc);
    exp_t  e;
    string t;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        timeout_fail($sformatf("unexpected_bundle pc=%h", out_pc));
      end else begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk(t, 128'(observed()), 128'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input exp_t e, input string tag, input bit push);
    bit acc;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = cur_pc;
    e.pc     = cur_pc;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    if (!acc) begin
      timeout_fail({tag, "_accept"});
    end else begin
      if (push) begin
        sb_q.push_back(e);
        tag_q.push_back(tag);
      end
      cur_pc = cur_pc + 32'd4;
    end
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick(acc);
    if (sb_q.size() != 0) timeout_fail("drain");
    repeat (2) tick(acc);
  endtask

  initial begin
    bit   acc;
    exp_t e_auipc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk("reset_payload", 128'(observed()), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back decode with execute always ready.
    out_ready = 1'b1;
    offer(32'h40B50533, mk(A_SUB, 5'd10, 5'd11, 5'd10, 32'h0, 7'b0010000, 3'd0, 1'b0), "sub", 1'b1);
    chk("latency_valid", 128'(out_valid), 128'(1'b1));
    chk("tput_in_ready", 128'(in_ready), 128'(1'b1));
    offer(32'hFFF00093, mk(A_ADD, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 7'b0110000, 3'd0, 1'b0), "addi", 1'b1);
    chk("tput_in_ready2", 128'(in_ready), 128'(1'b1));
    offer(32'h40335293, mk(A_SRA, 5'd6, 5'd3, 5'd5, 32'h3, 7'b0110000, 3'd5, 1'b0), "srai", 1'b1);
    offer(32'h0020E463, mk(A_LTU, 5'd1, 5'd2, 5'd8, 32'h8, 7'b0000010, 3'd6, 1'b0), "bltu", 1'b1);
    offer(32'h0F04F493, mk(A_AND, 5'd9, 5'd16, 5'd9, 32'hF0, 7'b0110000, 3'd7, 1'b0), "andi", 1'b1);
    offer(32'h010000EF, mk(A_ADD, 5'd0, 5'd16, 5'd1, 32'h10, 7'b1110001, 3'd0, 1'b0), "jal", 1'b1);
    offer(32'h00008067, mk(A_ADD, 5'd1, 5'd0, 5'd0, 32'h0, 7'b0100001, 3'd0, 1'b0), "jalr_x0", 1'b1);
    drain();

    // Stall: two accepted into output+skid, third held off until execute is ready.
    out_ready = 1'b0;
    e_auipc = mk(A_ADD, 5'd0, 5'd0, 5'd7, 32'h1000, 7'b1110000, 3'd1, 1'b0);
    offer(32'h00001397, e_auipc, "auipc", 1'b1);
    offer(32'h00812203, mk(A_ADD, 5'd2, 5'd8, 5'd4, 32'h8, 7'b0111000, 3'd2, 1'b0), "lw", 1'b1);
    in_valid = 1'b1;
    in_instr = 32'h00532623;
    in_pc    = cur_pc;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 128'(in_ready), 128'(1'b0));
      chk("stall_hold", 128'(observed()), 128'(sb_q[0]));
      tick(acc);
    end
    out_ready = 1'b1;
    offer(32'h00532623, mk(A_ADD, 5'd6, 5'd5, 5'd12, 32'hC, 7'b0100100, 3'd2, 1'b0), "sw", 1'b1);
    drain();

    // Illegal encodings flow through with side effects suppressed.
    offer(32'h00000000, mk(A_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 7'b0000000, 3'd0, 1'b1), "ill_zero", 1'b1);
    offer(32'h002081B3, mk(A_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 7'b0010000, 3'd0, 1'b0), "add_after_ill", 1'b1);
    offer(32'h4020C1B3, mk(A_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 7'b0000000, 3'd4, 1'b1), "ill_op_f7", 1'b1);
    offer(32'h00000073, mk(A_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 7'b0000000, 3'd0, 1'b1), "ill_system", 1'b1);
    offer(32'h0020A463, mk(A_ADD, 5'd1, 5'd2, 5'd8, 32'h8, 7'b0000000, 3'd2, 1'b1), "ill_branch", 1'b1);
    drain();

    // Flush while full with an input offered in the same cycle.
    out_ready = 1'b0;
    offer(32'h00100093, mk(A_ADD, 5'd0, 5'd1, 5'd1, 32'h1, 7'b0110000, 3'd0, 1'b0), "fl_a", 1'b0);
    offer(32'h00200113, mk(A_ADD, 5'd0, 5'd2, 5'd2, 32'h2, 7'b0110000, 3'd0, 1'b0), "fl_b", 1'b0);
    chk("two_in_ready", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b1;
    in_instr = 32'h00300193;
    flush    = 1'b1;
    tick(acc);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
    chk("flush_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    offer(32'h002081B3, mk(A_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 7'b0010000, 3'd0, 1'b0), "post_flush", 1'b1);
    drain();

    // Asynchronous reset mid-stream, checked before any clock edge.
    out_ready = 1'b0;
    offer(32'h00100093, mk(A_ADD, 5'd0, 5'd1, 5'd1, 32'h1, 7'b0110000, 3'd0, 1'b0), "rs_a", 1'b0);
    offer(32'h00200113, mk(A_ADD, 5'd0, 5'd2, 5'd2, 32'h2, 7'b0110000, 3'd0, 1'b0), "rs_b", 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("arst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("arst_payload", 128'(observed()), 128'(0));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    offer(32'h40B50533, mk(A_SUB, 5'd10, 5'd11, 5'd10, 32'h0, 7'b0010000, 3'd0, 1'b0), "post_reset", 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
